// File: rtl/histogram_compressor.sv
// Joint histogram of two unary bitstreams over a window of STREAM_LENGTH beats.
// The four bin totals and the beat total are published over a valid/ready handshake.
module histogram_compressor #(
  parameter int unsigned STREAM_LENGTH = 128,
  parameter int unsigned COUNTER_WIDTH = $clog2(STREAM_LENGTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_compress,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic                     stream_a,
  input  logic                     stream_b,
  output logic                     in_ready,
  output logic [COUNTER_WIDTH-1:0] count_00,
  output logic [COUNTER_WIDTH-1:0] count_01,
  output logic [COUNTER_WIDTH-1:0] count_10,
  output logic [COUNTER_WIDTH-1:0] count_11,
  output logic [COUNTER_WIDTH-1:0] beat_count,
  output logic                     hist_valid,
  input  logic                     hist_ready,
  output logic                     compress_done
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;
  typedef logic [COUNTER_WIDTH-1:0] cnt_t;

  localparam cnt_t LastBeat = cnt_t'(STREAM_LENGTH - 1);
  localparam cnt_t One      = cnt_t'(1);

  state_e state_q, state_d;
  cnt_t   bin_q [4];
  cnt_t   bin_d [4];
  cnt_t   out_q [4];
  cnt_t   out_d [4];
  cnt_t   beat_q, beat_d;
  cnt_t   beat_out_q, beat_out_d;
  logic   in_ready_q, in_ready_d;
  logic   hist_valid_q, hist_valid_d;
  logic   done_q, done_d;
  logic   accept;
  logic [1:0] idx;

  assign accept = (state_q == StAccum) && in_valid;
  assign idx    = {stream_a, stream_b};

  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    out_d        = out_q;
    beat_d       = beat_q;
    beat_out_d   = beat_out_q;
    in_ready_d   = in_ready_q;
    hist_valid_d = hist_valid_q;
    done_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_compress) begin
          for (int i = 0; i < 4; i++) bin_d[i] = '0;
          beat_d     = '0;
          in_ready_d = 1'b1;
          state_d    = StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          bin_d[idx] = bin_q[idx] + One;
          beat_d     = beat_q + One;
        end
        // Publish totals that already include a beat accepted on the closing edge.
        if (flush || (accept && (beat_q == LastBeat))) begin
          out_d        = bin_d;
          beat_out_d   = beat_d;
          hist_valid_d = 1'b1;
          in_ready_d   = 1'b0;
          state_d      = StHold;
        end
      end
      StHold: begin
        if (hist_ready) begin
          hist_valid_d = 1'b0;
          done_d       = 1'b1;
          state_d      = StIdle;
        end
      end
      default: begin
        in_ready_d   = 1'b0;
        hist_valid_d = 1'b0;
        state_d      = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      for (int i = 0; i < 4; i++) begin
        bin_q[i] <= '0;
        out_q[i] <= '0;
      end
      beat_q       <= '0;
      beat_out_q   <= '0;
      in_ready_q   <= 1'b0;
      hist_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      out_q        <= out_d;
      beat_q       <= beat_d;
      beat_out_q   <= beat_out_d;
      in_ready_q   <= in_ready_d;
      hist_valid_q <= hist_valid_d;
      done_q       <= done_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign count_00      = out_q[0];
  assign count_01      = out_q[1];
  assign count_10      = out_q[2];
  assign count_11      = out_q[3];
  assign beat_count    = beat_out_q;
  assign hist_valid    = hist_valid_q;
  assign compress_done = done_q;

endmodule

// File: tb/tb_histogram_compressor.sv
// Directed bench for histogram_compressor: expected histograms are queued per window and
// compared by a monitor when hist_valid rises.
module tb_histogram_compressor;

  localparam int unsigned CW = 8;
  typedef logic [5*CW-1:0] hist_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start_compress, flush, in_valid, stream_a, stream_b, hist_ready;
  logic in_ready, hist_valid, compress_done;
  logic [CW-1:0] count_00, count_01, count_10, count_11, beat_count;

  int total = 0;
  int bad   = 0;
  hist_t exp_q[$];

  histogram_compressor #(
    .STREAM_LENGTH(128)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_compress(start_compress),
    .flush         (flush),
    .in_valid      (in_valid),
    .stream_a      (stream_a),
    .stream_b      (stream_b),
    .in_ready      (in_ready),
    .count_00      (count_00),
    .count_01      (count_01),
    .count_10      (count_10),
    .count_11      (count_11),
    .beat_count    (beat_count),
    .hist_valid    (hist_valid),
    .hist_ready    (hist_ready),
    .compress_done (compress_done)
  );

  always #5 clk = ~clk;

  function automatic hist_t mk(input int c00, input int c01, input int c10, input int c11,
                               input int b);
    return {CW'(c00), CW'(c01), CW'(c10), CW'(c11), CW'(b)};
  endfunction

  function automatic hist_t cur();
    return {count_00, count_01, count_10, count_11, beat_count};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each rising hist_valid must match the oldest queued window.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (hist_valid && !prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got %0h expected none", cur());
        end else begin
          check("sb_hist", 64'(cur()), 64'(exp_q.pop_front()));
          check("sb_in_ready_low", 64'(in_ready), 64'(0));
        end
      end
      prev = hist_valid;
    end
  end

  task automatic start();
    @(negedge clk);
    start_compress = 1'b1;
    @(negedge clk);
    start_compress = 1'b0;
    check("start_in_ready", 64'(in_ready), 64'(1));
  endtask

  task automatic beat(input logic a, input logic b);
    @(negedge clk);
    in_valid = 1'b1;
    stream_a = a;
    stream_b = b;
  endtask

  task automatic end_beats(input string name);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    check(name, 64'(hist_valid), 64'(1));
  endtask

  // Hold off hist_ready for wait_cycles, then transfer; optionally restart in the done cycle.
  task automatic release_hist(input int wait_cycles, input hist_t e, input bit chain);
    for (int i = 0; i < wait_cycles; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(hist_valid), 64'(1));
      check("hold_counts", 64'(cur()), 64'(e));
    end
    @(negedge clk);
    hist_ready = 1'b1;
    @(negedge clk);
    hist_ready = 1'b0;
    check("xfer_valid_low", 64'(hist_valid), 64'(0));
    check("done_pulse", 64'(compress_done), 64'(1));
    if (chain) start_compress = 1'b1;
    @(negedge clk);
    start_compress = 1'b0;
    check("done_single", 64'(compress_done), 64'(0));
    check("counts_kept", 64'(cur()), 64'(e));
    if (chain) check("chain_in_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    hist_t e;
    rst_n = 1'b0;
    {start_compress, flush, in_valid, stream_a, stream_b, hist_ready} = '0;
    repeat (3) @(negedge clk);
    check("rst_counts", 64'(cur()), 64'(0));
    check("rst_flags", 64'({in_ready, hist_valid, compress_done}), 64'(0));
    rst_n = 1'b1;

    // Reset in the middle of a window, then a full {1,0} window.
    start();
    for (int i = 0; i < 10; i++) beat(1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("async_rst_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 64'({in_ready, hist_valid}), 64'(0));
    check("post_rst_counts", 64'(cur()), 64'(0));
    e = mk(0, 0, 128, 0, 128);
    exp_q.push_back(e);
    start();
    for (int i = 0; i < 128; i++) beat(1'b1, 1'b0);
    end_beats("w1_valid");
    release_hist(0, e, 1'b0);

    // Full window cycling 00,01,10,11; valid must not rise before the last edge.
    e = mk(32, 32, 32, 32, 128);
    exp_q.push_back(e);
    start();
    for (int i = 0; i < 128; i++) begin
      beat(i[1], i[0]);
      if (i == 127) check("w2_valid_late", 64'(hist_valid), 64'(0));
    end
    end_beats("w2_valid");
    @(negedge clk);
    check("w2_ready_low", 64'(in_ready), 64'(0));
    release_hist(0, e, 1'b0);

    // Gapped input with 20 cycles of backpressure.
    e = mk(43, 45, 15, 25, 128);
    exp_q.push_back(e);
    start();
    for (int i = 0; i < 128; i++) begin
      beat(i < 40, (i < 25) || (i >= 40 && i < 85));
      @(negedge clk);
      in_valid = 1'b0;
      stream_a = 1'($urandom());
      stream_b = 1'($urandom());
    end
    check("w3_valid", 64'(hist_valid), 64'(1));
    release_hist(20, e, 1'b0);

    // Early flush coinciding with a beat.
    e = mk(0, 1, 0, 5, 6);
    exp_q.push_back(e);
    start();
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b1);
    beat(1'b0, 1'b1);
    flush = 1'b1;
    end_beats("w4_valid");
    release_hist(2, e, 1'b0);

    // Ignored controls in IDLE.
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    stream_a = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("idle_ignore_flags", 64'({in_ready, hist_valid}), 64'(0));
    check("idle_ignore_counts", 64'(cur()), 64'(e));

    // start_compress mid-window must not clear bins; controls in HOLD are ignored.
    e = mk(3, 0, 0, 2, 5);
    exp_q.push_back(e);
    start();
    for (int i = 0; i < 3; i++) beat(1'b0, 1'b0);
    @(negedge clk);
    in_valid       = 1'b0;
    start_compress = 1'b1;
    @(negedge clk);
    start_compress = 1'b0;
    for (int i = 0; i < 2; i++) beat(1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    end_beats("w5_valid");
    start_compress = 1'b1;
    in_valid       = 1'b1;
    flush          = 1'b1;
    @(negedge clk);
    {start_compress, in_valid, flush} = '0;
    @(negedge clk);
    check("hold_ignore_flags", 64'({in_ready, hist_valid}), 64'(1));
    check("hold_ignore_counts", 64'(cur()), 64'(e));
    e = mk(0, 0, 0, 0, 0);
    exp_q.push_back(e);
    release_hist(1, mk(3, 0, 0, 2, 5), 1'b1);

    // Back-to-back window closed by flush with no beats.
    @(negedge clk);
    flush = 1'b1;
    end_beats("w6_valid");
    release_hist(0, e, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/histogram_compressor.md
Name: histogram_compressor

Overview:
Upstream stage of histogram_decompressor. Accepts two parallel unary bitstreams (stream_a, stream_b) one bit-pair per accepted beat over a window of STREAM_LENGTH beats. Accumulates the joint histogram of the pairs {a,b} into four bins and publishes count_00..count_11 through a valid/ready handshake. The published counts are exactly the count_* inputs that histogram_decompressor latches on start_decompress.

Parameters:
STREAM_LENGTH, 128, beats per window; also the sum of the four published counts for a full window.
COUNTER_WIDTH, $clog2(STREAM_LENGTH+1), width of every bin and beat counter; holds 0..STREAM_LENGTH inclusive.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start_compress  input  1  begin a new window; honoured only in IDLE.
flush  input  1  end the current window early; honoured only in ACCUM.
in_valid  input  1  stream_a/stream_b carry a valid bit-pair.
stream_a  input  1  bit of stream A.
stream_b  input  1  bit of stream B.
in_ready  output  1  block accepts a bit-pair; a beat transfers when in_valid and in_ready are both 1.
count_00  output  COUNTER_WIDTH  published count of pairs {a,b}=00.
count_01  output  COUNTER_WIDTH  published count of pairs 01.
count_10  output  COUNTER_WIDTH  published count of pairs 10.
count_11  output  COUNTER_WIDTH  published count of pairs 11.
beat_count  output  COUNTER_WIDTH  published number of beats in the window (sum of the four counts).
hist_valid  output  1  published histogram is valid.
hist_ready  input  1  consumer accepts the histogram; transfer when hist_valid and hist_ready are both 1.
compress_done  output  1  one-cycle pulse on the cycle after the histogram transfer.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All working counters 0. count_* 0, beat_count 0. in_ready, hist_valid and compress_done all 0. Reset mid-window discards all partial counts.
- States: IDLE, ACCUM, HOLD. State and all outputs are registered. in_ready = (state==ACCUM).
- IDLE: start_compress=1 clears the four working bins and the working beat counter, then moves to ACCUM on the next edge. in_valid is ignored in IDLE. flush is ignored.
- ACCUM, on each accepted beat:
  - the working bin indexed by {stream_a,stream_b} increments by 1;
  - the working beat counter increments by 1.
- Window end. The window ends on the edge of the beat that brings the beat counter to STREAM_LENGTH, or on the edge where flush=1.
  - At that edge, count_* and beat_count load the final totals, including any beat accepted on that same edge.
  - hist_valid goes to 1, in_ready goes to 0, and state becomes HOLD.
  - Latency: the last beat is accepted at edge N; hist_valid=1 is visible in the cycle after edge N, with the outputs already updated.
- flush and an accepted beat in the same cycle: the beat is counted, then the window closes.
- flush with zero accepted beats: a histogram of all zeros is published, with beat_count=0.
- start_compress is ignored in ACCUM and HOLD.
- HOLD:
  - count_*, beat_count and hist_valid are held stable until hist_ready=1.
  - On the transfer edge: hist_valid returns to 0, compress_done pulses 1 for exactly one cycle, and state returns to IDLE.
  - count_* and beat_count keep their last values after the transfer.
  - hist_ready=0 indefinitely means the block stays in HOLD. hist_ready is ignored outside HOLD.
- Arithmetic:
  - Counters never exceed STREAM_LENGTH, and no bin can wrap.
  - Invariant: count_00+count_01+count_10+count_11 == beat_count <= STREAM_LENGTH.
- A new start_compress in the same cycle as compress_done is high: the block is in IDLE, so the new window starts. Back-to-back windows are therefore possible with one idle cycle between them.

Test Plan:
- Reset values: assert rst_n=0 mid-ACCUM after 10 beats, then release -> all outputs 0, state IDLE; then start_compress plus 128 beats of {1,0} -> count_10=128, others 0, beat_count=128.
- Mixed full window: start, then 128 beats cycling 00,01,10,11 with in_valid always 1 -> hist_valid rises the cycle after the 128th beat; each count is 32; beat_count=128; in_ready=0 from then on.
- Gapped input plus backpressure: in_valid toggling 1/0 for 128 accepted beats (a=1 on 40 beats, b=1 on 70, both 1 on 25), hist_ready held 0 for 20 cycles -> counts 11:25, 10:15, 01:45, 00:43; hist_valid and the counts stay stable for all 20 cycles; compress_done pulses one cycle after hist_ready=1.
- Early flush: 5 beats {1,1}, then flush together with a 6th beat {0,1} -> count_11=5, count_01=1, beat_count=6.
- Flush with no beats -> all counts 0, beat_count=0, hist_valid=1.
- Ignored controls: pulse start_compress during ACCUM and during HOLD, pulse flush in IDLE, drive in_valid=1 in IDLE and HOLD -> no state change and no count change.
- Chaining: feed the outputs into histogram_decompressor, with start_decompress driven by the hist_valid&&hist_ready handshake -> the decompressor emits 128 beats whose pair counts equal the published count_*.
